// File: rtl/mu_velocity_read_sequencer_if.sv
// -----------------------------------------------------------------------------
// mu_velocity_read_sequencer_if
//
// Groups the sequencer's cache read bus and its output velocity stream.
//
//   Cache side:
//     MU_rd_addr          shared particle-slot read address for all cell caches
//     MU_rden             shared read enable
//     velocity_data_out   per-cell read data, {z,y,x} per cell
//   Stream side:
//     vel_data            velocity {z,y,x}
//     vel_cell_id         cell coordinate {x,y,z}, 1-based
//     vel_particle_id     particle slot within the cell
//     vel_valid           stream valid
//     vel_ready           stream ready
//
// Modports:
//   master  - the sequencer (drives read bus and stream, consumes data/ready)
//   slave   - the environment (caches plus the motion-update arithmetic)
// -----------------------------------------------------------------------------
interface mu_velocity_read_sequencer_if #(
  parameter int NUM_CELLS         = 125,
  parameter int DATA_WIDTH        = 32,
  parameter int CELL_ID_WIDTH     = 3,
  parameter int PARTICLE_ID_WIDTH = 7
);
  logic [PARTICLE_ID_WIDTH-1:0]            MU_rd_addr;
  logic                                    MU_rden;
  logic [NUM_CELLS-1:0][3*DATA_WIDTH-1:0]  velocity_data_out;
  logic [3*DATA_WIDTH-1:0]                 vel_data;
  logic [3*CELL_ID_WIDTH-1:0]              vel_cell_id;
  logic [PARTICLE_ID_WIDTH-1:0]            vel_particle_id;
  logic                                    vel_valid;
  logic                                    vel_ready;

  modport master (
    output MU_rd_addr, MU_rden, vel_data, vel_cell_id, vel_particle_id, vel_valid,
    input  velocity_data_out, vel_ready
  );

  modport slave (
    input  MU_rd_addr, MU_rden, vel_data, vel_cell_id, vel_particle_id, vel_valid,
    output velocity_data_out, vel_ready
  );
endinterface

// File: rtl/mu_velocity_read_sequencer.sv
// -----------------------------------------------------------------------------
// mu_velocity_read_sequencer
//
// Walks every cell during the motion-update phase, reads each valid particle
// velocity from the per-cell caches and streams the results (tagged with cell
// coordinate and particle slot) over a valid/ready interface. Reads are only
// issued when the output FIFO is guaranteed to have room for them once the
// fixed cache read latency has elapsed, so backpressure never loses data.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   Motion_Update_enable   rising edge starts a sweep (ignored outside IDLE)
//   cell_particle_num      particle count per cell, stable during a sweep
//   bus (master modport)   cache read bus + output velocity stream
//   sweep_done             one-cycle pulse when a sweep has fully drained
//   stall_cycles           stall counter (0 unless the macro below is defined)
//
// Build option:
//   MU_VEL_SEQ_STALL_CNT_EN  when defined, stall_cycles counts cycles where the
//                            stream is held by the consumer or an issue-state
//                            read is blocked by credits. Cleared on the start
//                            edge, saturating, held after the sweep ends.
// -----------------------------------------------------------------------------
module mu_velocity_read_sequencer #(
  parameter int NUM_CELLS             = 125,
  parameter int CELLS_PER_DIM         = 5,
  parameter int DATA_WIDTH            = 32,
  parameter int CELL_ID_WIDTH         = 3,
  parameter int NUM_PARTICLE_PER_CELL = 128,
  parameter int PARTICLE_ID_WIDTH     = 7,
  parameter int RD_LATENCY            = 2,
  parameter int FIFO_DEPTH            = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    Motion_Update_enable,
  input  logic [NUM_CELLS-1:0][PARTICLE_ID_WIDTH:0] cell_particle_num,
  mu_velocity_read_sequencer_if.master            bus,
  output logic                                    sweep_done,
  output logic [31:0]                             stall_cycles
);

  localparam int IDX_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;
  localparam int NW    = PARTICLE_ID_WIDTH + 1;
  localparam int CID_W = 3 * CELL_ID_WIDTH;
  localparam int VW    = 3 * DATA_WIDTH;

  localparam logic [NW-1:0]            N_MAX    = NW'(NUM_PARTICLE_PER_CELL);
  localparam logic [CELL_ID_WIDTH-1:0] CPD_C    = CELL_ID_WIDTH'(CELLS_PER_DIM);
  localparam logic [CELL_ID_WIDTH-1:0] CID_ONE  = CELL_ID_WIDTH'(1);
  localparam logic [IDX_W-1:0]         IDX_LAST = IDX_W'(NUM_CELLS - 1);
  localparam logic [PTR_W-1:0]         PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic                         valid;
    logic [IDX_W-1:0]             idx;
    logic [CID_W-1:0]             cell_id;
    logic [PARTICLE_ID_WIDTH-1:0] pid;
  } tag_t;

  typedef struct packed {
    logic [VW-1:0]                data;
    logic [CID_W-1:0]             cell_id;
    logic [PARTICLE_ID_WIDTH-1:0] pid;
  } entry_t;

  state_t                       state_q, state_d;
  logic                         en_prev_q;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [CELL_ID_WIDTH-1:0]     cx_q, cx_d, cy_q, cy_d, cz_q, cz_d;
  logic [PARTICLE_ID_WIDTH-1:0] pid_q, pid_d;
  tag_t                         tag_q [RD_LATENCY];
  tag_t                         tag_d [RD_LATENCY];
  tag_t                         tag_last;
  entry_t                       fifo_mem [FIFO_DEPTH];
  entry_t                       push_entry, head;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d, inflight;
  logic [NW-1:0]                n_raw, n_cur;
  logic                         start, vel_valid, pop, push, rden, credit_ok;
  logic                         last_cell, last_pid, advance;

  // ---------------------------------------------------------------------------
  // Per-cell read count and credit check
  // ---------------------------------------------------------------------------
  assign start     = Motion_Update_enable & ~en_prev_q;
  assign n_raw     = cell_particle_num[idx_q];
  assign n_cur     = (n_raw > N_MAX) ? N_MAX : n_raw;
  assign last_pid  = ({1'b0, pid_q} == (n_cur - NW'(1)));
  assign last_cell = (idx_q == IDX_LAST);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CNT_W'(tag_q[i].valid);
    end
  end

  assign vel_valid = (count_q != '0);
  assign pop       = vel_valid & bus.vel_ready;
  // Every read in flight already owns a FIFO slot; a slot freed by this
  // cycle's pop may be reused immediately.
  assign credit_ok = (inflight + count_q - CNT_W'(pop)) < CNT_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Sweep control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    cz_d    = cz_q;
    pid_d   = pid_q;
    rden    = 1'b0;
    advance = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          idx_d   = '0;
          cx_d    = CID_ONE;
          cy_d    = CID_ONE;
          cz_d    = CID_ONE;
          pid_d   = '0;
        end
      end

      S_ISSUE: begin
        if (n_cur == '0) begin
          // Empty cell: one bubble, no read.
          advance = 1'b1;
        end else if (credit_ok) begin
          rden = 1'b1;
          if (last_pid) begin
            pid_d   = '0;
            advance = 1'b1;
          end else begin
            pid_d = pid_q + 1'b1;
          end
        end

        if (advance) begin
          if (last_cell) begin
            state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + 1'b1;
            // z fastest, then y, then x -- matches the linear index order.
            if (cz_q == CPD_C) begin
              cz_d = CID_ONE;
              if (cy_q == CPD_C) begin
                cy_d = CID_ONE;
                cx_d = cx_q + 1'b1;
              end else begin
                cy_d = cy_q + 1'b1;
              end
            end else begin
              cz_d = cz_q + 1'b1;
            end
          end
        end
      end

      S_DRAIN: begin
        if (inflight == '0 && count_q == '0) begin
          state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline: follows each read through the cache latency
  // ---------------------------------------------------------------------------
  assign tag_d[0] = {rden, idx_q, cx_q, cy_q, cz_q, pid_q};

  generate
    for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_tag
      assign tag_d[gi] = tag_q[gi-1];
    end
  endgenerate

  assign tag_last   = tag_q[RD_LATENCY-1];
  assign push       = tag_last.valid;
  assign push_entry = {bus.velocity_data_out[tag_last.idx], tag_last.cell_id, tag_last.pid};

  // ---------------------------------------------------------------------------
  // Show-ahead output FIFO
  // ---------------------------------------------------------------------------
  assign wr_ptr_d = push ? ((wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? ((rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  assign head     = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= push_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      en_prev_q <= 1'b0;
      idx_q     <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      cz_q      <= '0;
      pid_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      en_prev_q <= Motion_Update_enable;
      idx_q     <= idx_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      cz_q      <= cz_d;
      pid_q     <= pid_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Stream fields are forced to zero while empty so that stale FIFO
  // contents never appear on the bus (including right after reset).
  // ---------------------------------------------------------------------------
  assign bus.MU_rden         = rden;
  assign bus.MU_rd_addr      = pid_q;
  assign bus.vel_valid       = vel_valid;
  assign bus.vel_data        = vel_valid ? head.data    : '0;
  assign bus.vel_cell_id     = vel_valid ? head.cell_id : '0;
  assign bus.vel_particle_id = vel_valid ? head.pid     : '0;
  assign sweep_done          = (state_q == S_DONE);

`ifdef MU_VEL_SEQ_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic        stall_event;

  assign stall_event = (vel_valid & ~bus.vel_ready) |
                       ((state_q == S_ISSUE) & (n_cur != '0) & ~credit_ok);

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start) begin
      stall_d = '0;
    end else if (stall_event && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mu_velocity_read_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mu_velocity_read_sequencer
//
// Directed sweeps with randomized counts, cache contents and ready patterns.
// The expected stream is derived directly from the cell/particle counts in
// sweep order; the cache is modelled as a fixed-latency lookup of a hash of
// (cell index, address).
// -----------------------------------------------------------------------------
module tb_mu_velocity_read_sequencer;

  localparam int NC  = 125;
  localparam int CPD = 5;
  localparam int DW  = 32;
  localparam int CW  = 3;
  localparam int PW  = 7;
  localparam int NPP = 128;
  localparam int FD  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en;
  logic [NC-1:0][PW:0]     counts;
  logic                    sweep_done;
  logic [31:0]             stall;

  always #5 clk = ~clk;

  mu_velocity_read_sequencer_if #(
    .NUM_CELLS(NC), .DATA_WIDTH(DW), .CELL_ID_WIDTH(CW), .PARTICLE_ID_WIDTH(PW)
  ) vif ();

  mu_velocity_read_sequencer dut (
    .clk                  (clk),
    .rst                  (rst),
    .Motion_Update_enable (en),
    .cell_particle_num    (counts),
    .bus                  (vif),
    .sweep_done           (sweep_done),
    .stall_cycles         (stall)
  );

  // ---------------------------------------------------------------------------
  // Cache model: two-cycle read latency, content is a hash of cell and address
  // ---------------------------------------------------------------------------
  int unsigned seed;
  logic        a1v, a2v;
  logic [PW-1:0] a1, a2;

  function automatic logic [3*DW-1:0] cache_word(input int unsigned s, input int c, input int a);
    logic [31:0] vx, vy, vz;
    vx = s ^ (32'(c) * 32'h9E3779B1) ^ 32'(a);
    vy = (s * 32'd3) + 32'(c) * 32'd977 + 32'(a) * 32'd131071;
    vz = {16'(c), 16'(a)} ^ s ^ 32'h5A5A5A5A;
    return {vz, vy, vx};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a1v <= 1'b0; a2v <= 1'b0; a1 <= '0; a2 <= '0;
    end else begin
      a1v <= vif.MU_rden; a1 <= vif.MU_rd_addr;
      a2v <= a1v;         a2 <= a1;
    end
  end

  always_comb begin
    for (int c = 0; c < NC; c++) begin
      vif.velocity_data_out[c] = a2v ? cache_word(seed, c, int'(a2))
                                     : {3{32'hDEAD0000 | 32'(c)}};
    end
  end

  // ---------------------------------------------------------------------------
  // Expected stream and bookkeeping
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3*CW-1:0] cid;
    logic [PW-1:0]   pid;
    logic [3*DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   rd_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt, rden_cnt, pop_cnt, first_rden_cyc, first_valid_cyc, done_cyc, start_cyc;
  bit hold_prev;
  logic [111:0] prev_fields;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected reads and outputs in sweep order: x slowest, z fastest.
  task automatic build_expect();
    exp_t e;
    int   idx, n;
    exp_q.delete();
    rd_q.delete();
    for (int x = 1; x <= CPD; x++)
      for (int y = 1; y <= CPD; y++)
        for (int z = 1; z <= CPD; z++) begin
          idx = (x-1)*CPD*CPD + (y-1)*CPD + (z-1);
          n   = (int'(counts[idx]) > NPP) ? NPP : int'(counts[idx]);
          for (int p = 0; p < n; p++) begin
            e.cid  = {CW'(x), CW'(y), CW'(z)};
            e.pid  = PW'(p);
            e.data = cache_word(seed, idx, p);
            exp_q.push_back(e);
            rd_q.push_back(p);
          end
        end
  endtask

  // One clock cycle: drive at the falling edge, observe 1ns later.
  task automatic tick(input bit rdy, input bit en_v);
    exp_t e;
    int   ra;
    logic [111:0] cur;
    @(negedge clk);
    vif.vel_ready = rdy;
    en = en_v;
    #1;
    cyc++;
    cur = {vif.vel_cell_id, vif.vel_particle_id, vif.vel_data};
    if (vif.MU_rden) begin
      rden_cnt++;
      if (first_rden_cyc < 0) first_rden_cyc = cyc;
      ra = (rd_q.size() > 0) ? rd_q.pop_front() : 255;
      check("rd_addr", 128'(vif.MU_rd_addr), 128'(ra));
    end
    if (hold_prev) begin
      check("hold_valid", 128'(vif.vel_valid), 128'(1));
      check("hold_fields", 128'(cur), 128'(prev_fields));
    end
    if (vif.vel_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (vif.vel_valid && vif.vel_ready) begin
      pop_cnt++;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin e.cid = '0; e.pid = '0; e.data = '0; end
      check("vel_out", 128'(cur), 128'({e.cid, e.pid, e.data}));
    end
    hold_prev   = vif.vel_valid && !vif.vel_ready;
    prev_fields = cur;
    if (sweep_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  // mode: 0 ready high, 1 ready toggling, 2 ready random, 3 ready low k=6..25
  task automatic run_sweep(input string name, input int mode, input int abort_after, input bit reedge);
    int budget, saved_rden, rden_before, win_reads;
    logic [31:0] stall0, stall1;
    bit rdy, en_v;
    seed = $urandom;
    build_expect();
    done_cnt = 0; rden_cnt = 0; pop_cnt = 0;
    first_rden_cyc = -1; first_valid_cyc = -1; done_cyc = -1;
    rden_before = 0; win_reads = 0; stall0 = '0; stall1 = '0;
    budget    = 4 * rd_q.size() + 400;
    start_cyc = cyc + 1;
    for (int k = 0; k < budget; k++) begin
      en_v = reedge ? (k < 3 || k >= 5) : (k < 2);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (k % 2) == 0;
        2:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = !(k >= 6 && k < 26);
      endcase
      if (k == 6) rden_before = rden_cnt;
      tick(rdy, en_v);
      if (mode == 3 && k == 6)  stall0 = stall;
      if (mode == 3 && k == 25) win_reads = rden_cnt - rden_before;
      if (mode == 3 && k == 26) stall1 = stall;
      if (abort_after > 0 && k + 1 >= abort_after) return;
      if (done_cnt > 0) break;
    end
    check({name, "_done_pulses"}, 128'(done_cnt), 128'(1));
    check({name, "_outputs_left"}, 128'(exp_q.size()), 128'(0));
    check({name, "_reads_left"}, 128'(rd_q.size()), 128'(0));
    if (mode == 3) begin
      check({name, "_window_reads_le_depth"}, 128'(win_reads <= FD), 128'(1));
`ifdef MU_VEL_SEQ_STALL_CNT_EN
      check({name, "_stall_start"}, 128'(stall0), 128'(0));
      check({name, "_stall_window"}, 128'(stall1 - stall0), 128'(20));
`else
      check({name, "_stall_tied_zero"}, 128'(stall1), 128'(0));
`endif
    end
    saved_rden = rden_cnt;
    repeat (12) tick(1'b1, 1'b0);
    check({name, "_post_done_pulses"}, 128'(done_cnt), 128'(1));
    check({name, "_post_no_reads"}, 128'(rden_cnt), 128'(saved_rden));
    check({name, "_post_idle_valid"}, 128'(vif.vel_valid), 128'(0));
    $display("sweep %s: reads=%0d outputs=%0d done_at=+%0d", name, rden_cnt, pop_cnt,
             done_cyc - start_cyc);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_rden"},      128'(vif.MU_rden), 128'(0));
    check({name, "_rd_addr"},   128'(vif.MU_rd_addr), 128'(0));
    check({name, "_valid"},     128'(vif.vel_valid), 128'(0));
    check({name, "_data"},      128'(vif.vel_data), 128'(0));
    check({name, "_cell_id"},   128'(vif.vel_cell_id), 128'(0));
    check({name, "_pid"},       128'(vif.vel_particle_id), 128'(0));
    check({name, "_done"},      128'(sweep_done), 128'(0));
    check({name, "_stall"},     128'(stall), 128'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; en = 1'b0; vif.vel_ready = 1'b0; counts = '0; seed = 32'd1;
    hold_prev = 1'b0; prev_fields = '0;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Two populated cells at the extremes of the sweep.
    counts = '0; counts[0] = 8'd3; counts[124] = 8'd2;
    run_sweep("two_cells", 0, 0, 1'b0);
    check("two_cells_outputs", 128'(pop_cnt), 128'(5));
    check("two_cells_first_read_latency", 128'(first_rden_cyc - start_cyc), 128'(1));
    check("two_cells_first_valid_latency", 128'(first_valid_cyc - first_rden_cyc), 128'(3));

    // All cells empty: one bubble per cell, no reads.
    counts = '0;
    run_sweep("all_empty", 0, 0, 1'b0);
    check("all_empty_reads", 128'(rden_cnt), 128'(0));
    check("all_empty_done_time", 128'(done_cyc - start_cyc), 128'(NC + 2));

    // Full cell followed by another cell (address wrap) and an over-full cell.
    counts = '0; counts[0] = 8'd128; counts[1] = 8'd5; counts[2] = 8'd130;
    run_sweep("full_toggle", 1, 0, 1'b0);
    check("full_toggle_outputs", 128'(pop_cnt), 128'(128 + 5 + 128));

    // Random occupancy with random backpressure.
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < NC; i++)
        counts[i] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 6)) : 8'd0;
      run_sweep("random", 2, 0, 1'b0);
    end

    // Consumer stalls for 20 cycles while data is waiting.
    counts = '0; counts[0] = 8'd10;
    run_sweep("ready_hold", 3, 0, 1'b0);

    // Asynchronous reset in the middle of a sweep, then a clean sweep.
    counts = '0; counts[0] = 8'd40; counts[60] = 8'd7;
    run_sweep("aborted", 2, 15, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    hold_prev = 1'b0;
    run_sweep("after_reset", 2, 0, 1'b0);

    // A second enable edge during ISSUE must not restart or repeat the sweep.
    for (int i = 0; i < NC; i++)
      counts[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 4)) : 8'd0;
    run_sweep("second_edge", 0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
